sdrc_bank_req_q: RTL and testbench
==================================

Name: sdrc_bank_req_q

Overview:
Responder end of the r2b request/acknowledge interface. Accepts page-bounded request chunks from the request generator and acknowledges them with b2r_ack. Gates new application requests with b2r_arb_ok. Buffers chunks in a DEPTH-entry FIFO and presents the head to the bank control state machines, together with an open-row hit indication from a per-bank open-row table.

Parameters:
APP_RW, 9, request length width in SDRAM words
REQ_ID_W, `SDR_REQ_ID_W, request ID width (from sdrc_define.v)
DEPTH, 4, FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
r2b_req  in  1  chunk request valid
r2b_req_id  in  REQ_ID_W  request ID
r2b_start  in  1  first chunk of application request
r2b_last  in  1  last chunk of application request
r2b_wrap  in  1  wrap mode
r2b_ba  in  2  bank address
r2b_raddr  in  12  row address
r2b_caddr  in  12  column address
r2b_len  in  APP_RW  chunk length
r2b_write  in  1  1 = write
b2r_ack  out  1  chunk accepted this cycle
b2r_arb_ok  out  1  new application request may start
x2b_pre_all  in  1  precharge-all/refresh issued; all rows closed
bq_valid  out  1  head entry valid
bq_id, bq_start, bq_last, bq_wrap, bq_ba, bq_raddr, bq_caddr, bq_len, bq_write  out  (as r2b)  head entry fields
bq_row_hit  out  1  head row already open in its bank
bq_pop  in  1  downstream consumes head; ignored when bq_valid=0
bq_count  out  clog2(DEPTH)+1  occupancy
proto_err  out  1  sticky protocol violation flag

Behaviour:
- Reset (reset_n=0 at a clk edge): FIFO empty; bq_count=0; bq_valid=0; proto_err=0; open-row table all invalid; burst FSM = IDLE; b2r_arb_ok=0 during reset, 1 on the first cycle after.
- Full is defined as bq_count==DEPTH.
- b2r_ack is combinational: r2b_req & (~full | (bq_pop & bq_valid)). Push while full is allowed only with a simultaneous pop.
- Push on b2r_ack writes all r2b fields into the tail entry. Latency: the entry is visible on bq_* the next cycle when the FIFO was empty. There is no bypass.
- Pop on bq_pop & bq_valid advances the head. The bq_* outputs are driven from the head entry; their values are don't-care when bq_valid=0.
- bq_count next value = count + push - pop. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- Burst FSM, two states:
  - IDLE: an accepted chunk with r2b_start=1 and r2b_last=0 moves to BURST. An accepted chunk with start=1 and last=1 stays in IDLE. An accepted chunk with start=0 sets proto_err.
  - BURST: an accepted chunk with last=1 returns to IDLE. An accepted chunk with start=1 sets proto_err; the chunk is still queued.
- b2r_arb_ok is registered. Next value = (FSM next == IDLE) & (bq_count next <= DEPTH-2), so at least two free entries remain for a split request.
- Open-row table: 4 entries of {valid, row[11:0]}.
  - Pop sets entry[bq_ba] = {1, bq_raddr}.
  - x2b_pre_all clears every valid bit. If pre_all and pop occur in the same cycle, pre_all wins and all entries end invalid.
- bq_row_hit is combinational: bq_valid & table[bq_ba].valid & (table[bq_ba].row == bq_raddr).
- proto_err stays set until reset.
- Reset mid-burst discards queued entries and returns the FSM to IDLE; no ack is issued in the reset cycle.

Decomposition:
- Package sdrc_bank_pkg: burst FSM state encoding (IDLE/BURST) and the r2b entry struct {id, start, last, wrap, ba, raddr, caddr, len, write}. Field widths are derived from APP_RW and `SDR_REQ_ID_W.
- One sub-module: sdrc_sync_fifo, a parameterised width/depth synchronous FIFO with push, pop, count, full and empty. The FSM, arb_ok logic and open-row table live in the top module.

Test Plan:
- Single chunk: reset, then r2b_req with start=1, last=1, ba=2, raddr=0x123, caddr=0x10, len=8. Expect b2r_ack=1 the same cycle; bq_valid=1 the next cycle with matching fields; bq_row_hit=0; bq_count=1; b2r_arb_ok stays 1.
- Split request: chunks {start=1, last=0, len=0x40} then {start=0, last=1, len=0x20}. Expect b2r_arb_ok=0 the cycle after the first ack, back to 1 after the second; two entries in order; proto_err=0.
- Full queue: DEPTH=4, no pops, hold r2b_req. Expect 4 acks, then b2r_ack=0 with bq_count=4. Assert bq_pop with r2b_req: expect b2r_ack=1 and bq_count stays 4.
- Row hit: pop an entry with ba=1, raddr=0x055, then present another ba=1, raddr=0x055 entry. Expect bq_row_hit=1. Pulse x2b_pre_all: expect bq_row_hit=0 the next cycle.
- Pre_all/pop collision: pre_all and pop of an entry with ba=0 in the same cycle. Expect table entry 0 invalid and a subsequent same-row head to give bq_row_hit=0.
- Protocol error: start=0 chunk in IDLE, then start=1 in BURST. Expect proto_err=1 sticky and chunks still acked; reset mid-BURST clears proto_err, bq_count=0 and the FSM to IDLE.

Source files
------------

// File: rtl/sdrc_bank_pkg.sv
// Shared types for the bank request queue: burst tracking states and the queued chunk record.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif

package sdrc_bank_pkg;

    localparam int unsigned BQ_APP_RW   = 9;
    localparam int unsigned BQ_REQ_ID_W = `SDR_REQ_ID_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_t;

    typedef struct packed {
        logic [BQ_REQ_ID_W-1:0] id;
        logic                   start;
        logic                   last;
        logic                   wrap;
        logic [1:0]             ba;
        logic [11:0]            raddr;
        logic [11:0]            caddr;
        logic [BQ_APP_RW-1:0]   len;
        logic                   write;
    } bq_entry_t;

endpackage

// File: rtl/sdrc_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; push while full succeeds only alongside a pop.
module sdrc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/sdrc_bank_req_q.sv
// Bank request queue: acknowledges r2b chunks, tracks burst framing, buffers chunks
// and flags whether the head row is already open in its bank.
module sdrc_bank_req_q
    import sdrc_bank_pkg::*;
#(
    parameter int unsigned APP_RW   = BQ_APP_RW,
    parameter int unsigned REQ_ID_W = BQ_REQ_ID_W,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     r2b_req,
    input  logic [REQ_ID_W-1:0]      r2b_req_id,
    input  logic                     r2b_start,
    input  logic                     r2b_last,
    input  logic                     r2b_wrap,
    input  logic [1:0]               r2b_ba,
    input  logic [11:0]              r2b_raddr,
    input  logic [11:0]              r2b_caddr,
    input  logic [APP_RW-1:0]        r2b_len,
    input  logic                     r2b_write,
    output logic                     b2r_ack,
    output logic                     b2r_arb_ok,
    input  logic                     x2b_pre_all,
    output logic                     bq_valid,
    output logic [REQ_ID_W-1:0]      bq_id,
    output logic                     bq_start,
    output logic                     bq_last,
    output logic                     bq_wrap,
    output logic [1:0]               bq_ba,
    output logic [11:0]              bq_raddr,
    output logic [11:0]              bq_caddr,
    output logic [APP_RW-1:0]        bq_len,
    output logic                     bq_write,
    output logic                     bq_row_hit,
    input  logic                     bq_pop,
    output logic [$clog2(DEPTH):0]   bq_count,
    output logic                     proto_err
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    bq_entry_t    wr_entry;
    bq_entry_t    head;
    burst_state_t state;
    burst_state_t state_next;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         err_set;
    logic         arb_ok_q;
    logic [CW-1:0] count_next;
    logic [3:0]   row_valid;
    logic [11:0]  row_addr [4];

    assign pop     = bq_pop & bq_valid;
    assign b2r_ack = reset_n & r2b_req & (~full | pop);
    assign push    = b2r_ack;

    assign wr_entry = '{id: r2b_req_id, start: r2b_start, last: r2b_last,
                        wrap: r2b_wrap, ba: r2b_ba, raddr: r2b_raddr,
                        caddr: r2b_caddr, len: r2b_len, write: r2b_write};

    sdrc_sync_fifo #(
        .WIDTH ($bits(bq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (wr_entry),
        .rdata   (head),
        .count   (bq_count),
        .full    (full),
        .empty   (empty)
    );

    assign bq_valid = ~empty;
    assign bq_id    = head.id;
    assign bq_start = head.start;
    assign bq_last  = head.last;
    assign bq_wrap  = head.wrap;
    assign bq_ba    = head.ba;
    assign bq_raddr = head.raddr;
    assign bq_caddr = head.caddr;
    assign bq_len   = head.len;
    assign bq_write = head.write;

    assign bq_row_hit = bq_valid & row_valid[bq_ba] & (row_addr[bq_ba] == bq_raddr);

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        if (push) begin
            unique case (state)
                ST_IDLE: begin
                    if (!r2b_start)    err_set    = 1'b1;
                    else if (!r2b_last) state_next = ST_BURST;
                end
                ST_BURST: begin
                    if (r2b_start) err_set    = 1'b1;
                    if (r2b_last)  state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign count_next = bq_count + CW'(push) - CW'(pop);

    // arb_ok resets high but is masked while in reset so it reads 1 on the first cycle after
    assign b2r_arb_ok = arb_ok_q & reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            proto_err <= 1'b0;
            arb_ok_q  <= 1'b1;
        end else begin
            state     <= state_next;
            proto_err <= proto_err | err_set;
            arb_ok_q  <= (state_next == ST_IDLE) && (count_next <= CW'(DEPTH - 2));
        end
    end

    // pre_all takes precedence over a same-cycle pop so the table never claims a closed row
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_valid <= '0;
            for (int unsigned i = 0; i < 4; i++) row_addr[i] <= '0;
        end else if (x2b_pre_all) begin
            row_valid <= '0;
        end else if (pop) begin
            row_valid[bq_ba] <= 1'b1;
            row_addr[bq_ba]  <= bq_raddr;
        end
    end

endmodule

// File: tb/tb_sdrc_bank_req_q.sv
// Directed bench for sdrc_bank_req_q with hand-computed expectations.
module tb_sdrc_bank_req_q;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        r2b_req;
    logic [3:0]  r2b_req_id;
    logic        r2b_start, r2b_last, r2b_wrap, r2b_write;
    logic [1:0]  r2b_ba;
    logic [11:0] r2b_raddr, r2b_caddr;
    logic [8:0]  r2b_len;
    logic        b2r_ack, b2r_arb_ok, x2b_pre_all;
    logic        bq_valid, bq_start, bq_last, bq_wrap, bq_write, bq_row_hit, bq_pop;
    logic [3:0]  bq_id;
    logic [1:0]  bq_ba;
    logic [11:0] bq_raddr, bq_caddr;
    logic [8:0]  bq_len;
    logic [2:0]  bq_count;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    sdrc_bank_req_q #(.APP_RW(9), .REQ_ID_W(4), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .r2b_req(r2b_req), .r2b_req_id(r2b_req_id),
        .r2b_start(r2b_start), .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_ba(r2b_ba),
        .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len), .r2b_write(r2b_write),
        .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok), .x2b_pre_all(x2b_pre_all),
        .bq_valid(bq_valid), .bq_id(bq_id), .bq_start(bq_start), .bq_last(bq_last),
        .bq_wrap(bq_wrap), .bq_ba(bq_ba), .bq_raddr(bq_raddr), .bq_caddr(bq_caddr),
        .bq_len(bq_len), .bq_write(bq_write), .bq_row_hit(bq_row_hit), .bq_pop(bq_pop),
        .bq_count(bq_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic l, input logic [1:0] ba,
                         input logic [11:0] ra, input logic [11:0] ca, input logic [8:0] len);
        r2b_req   = 1'b1;
        r2b_start = s;
        r2b_last  = l;
        r2b_ba    = ba;
        r2b_raddr = ra;
        r2b_caddr = ca;
        r2b_len   = len;
    endtask

    task automatic do_reset();
        r2b_req = 1'b0; bq_pop = 1'b0; x2b_pre_all = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        r2b_req_id = 4'h0; r2b_wrap = 1'b0; r2b_write = 1'b0;
        bq_pop = 1'b0; x2b_pre_all = 1'b0;
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 12'h0, 12'h0, 9'd1);
        tick();
        tick();
        checks++; if (b2r_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", b2r_ack); end
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bq_count); end
        checks++; if (bq_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bq_valid); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto got %b exp 0", proto_err); end
        checks++; if (b2r_arb_ok !== 1'b0) begin errors++; $display("FAIL rst_arb got %b exp 0", b2r_arb_ok); end
        r2b_req = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (b2r_arb_ok !== 1'b1) begin errors++; $display("FAIL rst_arb_after got %b exp 1", b2r_arb_ok); end
    endtask

    task automatic test_single();
        do_reset();
        r2b_req_id = 4'h3; r2b_write = 1'b1;
        drive(1'b1, 1'b1, 2'd2, 12'h123, 12'h010, 9'd8);
        #1;
        checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", b2r_ack); end
        tick();
        r2b_req = 1'b0; r2b_write = 1'b0;
        #1;
        checks++; if (bq_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bq_valid); end
        checks++;
        if ({bq_id, bq_start, bq_last, bq_ba, bq_raddr, bq_caddr, bq_len, bq_write} !==
            {4'h3, 1'b1, 1'b1, 2'd2, 12'h123, 12'h010, 9'd8, 1'b1}) begin
            errors++;
            $display("FAIL single_fields got id=%h ba=%0d ra=%h ca=%h len=%0d wr=%b exp id=3 ba=2 ra=123 ca=010 len=8 wr=1",
                     bq_id, bq_ba, bq_raddr, bq_caddr, bq_len, bq_write);
        end
        checks++; if (bq_row_hit !== 1'b0) begin errors++; $display("FAIL single_hit got %b exp 0", bq_row_hit); end
        checks++; if (bq_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", bq_count); end
        checks++; if (b2r_arb_ok !== 1'b1) begin errors++; $display("FAIL single_arb got %b exp 1", b2r_arb_ok); end
    endtask

    task automatic test_split();
        do_reset();
        drive(1'b1, 1'b0, 2'd0, 12'h001, 12'h000, 9'h40);
        #1;
        checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL split_ack1 got %b exp 1", b2r_ack); end
        tick();
        checks++; if (b2r_arb_ok !== 1'b0) begin errors++; $display("FAIL split_arb_mid got %b exp 0", b2r_arb_ok); end
        drive(1'b0, 1'b1, 2'd0, 12'h001, 12'h040, 9'h20);
        tick();
        r2b_req = 1'b0;
        #1;
        checks++; if (b2r_arb_ok !== 1'b1) begin errors++; $display("FAIL split_arb_end got %b exp 1", b2r_arb_ok); end
        checks++; if (bq_len !== 9'h40 || bq_start !== 1'b1) begin errors++; $display("FAIL split_head1 got len=%h start=%b exp len=40 start=1", bq_len, bq_start); end
        bq_pop = 1'b1;
        tick();
        bq_pop = 1'b0;
        checks++; if (bq_len !== 9'h20 || bq_last !== 1'b1) begin errors++; $display("FAIL split_head2 got len=%h last=%b exp len=20 last=1", bq_len, bq_last); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL split_proto got %b exp 0", proto_err); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'd3, 12'h200, 12'h000, 9'(i + 1));
            #1;
            checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL full_ack%0d got %b exp 1", i, b2r_ack); end
            tick();
        end
        drive(1'b1, 1'b1, 2'd3, 12'h200, 12'h000, 9'd5);
        #1;
        checks++; if (b2r_ack !== 1'b0) begin errors++; $display("FAIL full_noack got %b exp 0", b2r_ack); end
        checks++; if (bq_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bq_count); end
        checks++; if (b2r_arb_ok !== 1'b0) begin errors++; $display("FAIL full_arb got %b exp 0", b2r_arb_ok); end
        bq_pop = 1'b1;
        #1;
        checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL full_popack got %b exp 1", b2r_ack); end
        tick();
        r2b_req = 1'b0;
        bq_pop = 1'b0;
        #1;
        checks++; if (bq_count !== 3'd4) begin errors++; $display("FAIL full_popcount got %0d exp 4", bq_count); end
    endtask

    task automatic test_back_to_back();
        // after test_full the queue holds lengths 2,3,4,5 with the write pointer wrapped
        bq_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bq_len !== 9'(i + 2)) begin errors++; $display("FAIL b2b_len%0d got %0d exp %0d", i, bq_len, i + 2); end
            tick();
        end
        bq_pop = 1'b0;
        #1;
        checks++; if (bq_valid !== 1'b0 || bq_count !== 3'd0) begin errors++; $display("FAIL b2b_empty got valid=%b count=%0d exp 0/0", bq_valid, bq_count); end
    endtask

    task automatic test_row_hit();
        do_reset();
        drive(1'b1, 1'b1, 2'd1, 12'h055, 12'h000, 9'd4);
        tick();
        tick();
        r2b_req = 1'b0;
        #1;
        checks++; if (bq_row_hit !== 1'b0) begin errors++; $display("FAIL hit_cold got %b exp 0", bq_row_hit); end
        bq_pop = 1'b1;
        tick();
        bq_pop = 1'b0;
        #1;
        checks++; if (bq_row_hit !== 1'b1) begin errors++; $display("FAIL hit_open got %b exp 1", bq_row_hit); end
        x2b_pre_all = 1'b1;
        tick();
        x2b_pre_all = 1'b0;
        #1;
        checks++; if (bq_row_hit !== 1'b0) begin errors++; $display("FAIL hit_preall got %b exp 0", bq_row_hit); end
    endtask

    task automatic test_collision();
        do_reset();
        drive(1'b1, 1'b1, 2'd0, 12'h0AA, 12'h000, 9'd4);
        tick();
        tick();
        r2b_req = 1'b0;
        bq_pop = 1'b1;
        x2b_pre_all = 1'b1;
        tick();
        bq_pop = 1'b0;
        x2b_pre_all = 1'b0;
        #1;
        checks++; if (bq_valid !== 1'b1 || bq_raddr !== 12'h0AA) begin errors++; $display("FAIL coll_head got valid=%b ra=%h exp 1/0aa", bq_valid, bq_raddr); end
        checks++; if (bq_row_hit !== 1'b0) begin errors++; $display("FAIL coll_hit got %b exp 0", bq_row_hit); end
    endtask

    task automatic test_proto_err();
        do_reset();
        drive(1'b0, 1'b1, 2'd0, 12'h001, 12'h000, 9'd1);
        #1;
        checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL proto_ack1 got %b exp 1", b2r_ack); end
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_idle got %b exp 1", proto_err); end
        drive(1'b1, 1'b0, 2'd0, 12'h001, 12'h000, 9'd2);
        tick();
        drive(1'b1, 1'b0, 2'd0, 12'h001, 12'h000, 9'd3);
        #1;
        checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL proto_ack3 got %b exp 1", b2r_ack); end
        tick();
        r2b_req = 1'b0;
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", proto_err); end
        checks++; if (bq_count !== 3'd3) begin errors++; $display("FAIL proto_count got %0d exp 3", bq_count); end
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 12'h001, 12'h000, 9'd4);
        #1;
        checks++; if (b2r_ack !== 1'b0) begin errors++; $display("FAIL proto_rstack got %b exp 0", b2r_ack); end
        tick();
        r2b_req = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (proto_err !== 1'b0 || bq_count !== 3'd0) begin errors++; $display("FAIL proto_rst got err=%b count=%0d exp 0/0", proto_err, bq_count); end
        drive(1'b1, 1'b1, 2'd0, 12'h001, 12'h000, 9'd5);
        tick();
        r2b_req = 1'b0;
        #1;
        checks++; if (b2r_arb_ok !== 1'b1 || proto_err !== 1'b0) begin errors++; $display("FAIL proto_idle_after got arb=%b err=%b exp 1/0", b2r_arb_ok, proto_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_full();
        test_back_to_back();
        test_row_hit();
        test_collision();
        test_proto_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
